// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin share of one hex byte display between four
// requesters. Each grant is held for at least dwell_cycles clocks.
// Optional build macro: HEX_DISPLAY_ARB_PRIORITY_EN (requester 0 high priority,
// wins any idle arbitration and preempts other owners).
module hex_display_arbiter #(
    parameter int unsigned dwell_cycles = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_byte,
    output logic [3:0]  gnt,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [7:0]  hex_byte
);

    localparam int CW = $clog2(dwell_cycles + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(dwell_cycles - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    last_q, last_d;
    logic          busy_q, busy_d;
    logic [7:0]    hex_q, hex_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    win_idx;
    logic          preempt;
    logic          other_pending;
    logic          do_grant;
    logic [1:0]    grant_idx;
    logic [7:0]    owner_byte;
    logic [7:0]    grant_byte;

    // Round-robin winner: first set req bit in order last+1, last+2, last+3, last.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        win_idx = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_q + 2'(k)]) win_idx = last_q + 2'(k);
        end
`ifdef HEX_DISPLAY_ARB_PRIORITY_EN
        if (req[0]) win_idx = 2'd0;
`endif
    end

    // Requester 0 may cut into another owner's dwell when priority is enabled.
    always_comb begin
`ifdef HEX_DISPLAY_ARB_PRIORITY_EN
        preempt = (state_q == S_HOLD) && (owner_q != 2'd0) && req[0];
`else
        preempt = 1'b0;
`endif
    end

    assign other_pending = |(req & ~(4'b0001 << owner_q));
    assign owner_byte    = req_byte[{owner_q, 3'b000} +: 8];

    // Next-state: arbitration in IDLE, dwell counting and the decision edge in HOLD.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        busy_d    = busy_q;
        hex_d     = hex_q;
        cnt_d     = cnt_q;
        do_grant  = 1'b0;
        grant_idx = win_idx;

        case (state_q)
            S_IDLE: begin
                if (|req) do_grant = 1'b1;
            end
            default: begin
                if (preempt) begin
                    do_grant  = 1'b1;
                    grant_idx = 2'd0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                    if (req[owner_q]) hex_d = owner_byte;
                end else if (other_pending) begin
                    do_grant = 1'b1;
                end else if (req[owner_q]) begin
                    // Sole requester keeps the display; restart its dwell.
                    cnt_d = '0;
                    hex_d = owner_byte;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
        endcase

        grant_byte = req_byte[{grant_idx, 3'b000} +: 8];
        if (do_grant) begin
            state_d = S_HOLD;
            gnt_d   = 4'b0001 << grant_idx;
            owner_d = grant_idx;
            last_d  = grant_idx;
            busy_d  = 1'b1;
            cnt_d   = '0;
            hex_d   = grant_byte;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            busy_q  <= 1'b0;
            hex_q   <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            hex_q   <= hex_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign hex_byte = hex_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter with dwell 4: directed scenarios followed by
// random traffic, all compared against a behavioural model of the grant rules.
module tb_hex_display_arbiter;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_byte;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  hex_byte;

    int checks = 0;
    int errors = 0;

    // Model state: who holds the display, how many cycles it has held it.
    bit       m_busy;
    int       m_owner;
    int       m_last;
    int       m_age;
    bit [7:0] m_hex;

    hex_display_arbiter #(.dwell_cycles(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_byte(req_byte),
        .gnt(gnt), .owner(owner), .busy(busy), .hex_byte(hex_byte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
`ifdef HEX_DISPLAY_ARB_PRIORITY_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        return last;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_owner = 0; m_last = 3; m_age = 0; m_hex = 8'h00;
    endtask

    task automatic m_grant(input int w, input logic [31:0] b);
        m_busy = 1; m_owner = w; m_last = w; m_age = 0; m_hex = b[8*w +: 8];
    endtask

    task automatic m_step(input logic [3:0] r, input logic [31:0] b);
        if (!m_busy) begin
            if (r != 0) m_grant(pick(r, m_last), b);
            return;
        end
`ifdef HEX_DISPLAY_ARB_PRIORITY_EN
        if (m_owner != 0 && r[0]) begin m_grant(0, b); return; end
`endif
        if (m_age < DW - 1) begin
            m_age++;
            if (r[m_owner]) m_hex = b[8*m_owner +: 8];
        end else begin
            logic [3:0] others;
            others = r;
            others[m_owner] = 1'b0;
            if (others != 0) m_grant(pick(r, m_last), b);
            else if (r[m_owner]) begin m_age = 0; m_hex = b[8*m_owner +: 8]; end
            else m_busy = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_gnt"},   gnt,      m_busy ? (32'h1 << m_owner) : 32'h0);
        chk({tag, "_owner"}, owner,    m_owner);
        chk({tag, "_busy"},  busy,     m_busy);
        chk({tag, "_hex"},   hex_byte, m_hex);
    endtask

    // One clock: apply inputs, let the edge happen, advance model, compare.
    task automatic cyc(input string tag, input logic [3:0] r, input logic [31:0] b);
        req = r; req_byte = b;
        @(posedge clk);
        m_step(r, b);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between edges, checked before any clock edge.
    task automatic pulse_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        m_reset();
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0; req_byte = 32'h0;
        m_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Single requester 2, request dropped immediately.
        cyc("s1_grant", 4'b0100, 32'h00A5_0000);
        chk("s1_gnt_direct", gnt, 4'b0100);
        chk("s1_hex_direct", hex_byte, 8'hA5);
        for (int i = 0; i < 6; i++) cyc("s1_dwell", 4'b0000, 32'h0);
        chk("s1_idle_gnt", gnt, 4'b0000);

        // All four requesting: round robin 0,1,2,3,0 from a fresh reset.
        pulse_reset("s2_rst");
        for (int i = 0; i < 4 * DW + 2; i++) begin
            cyc("s2_rr", 4'b1111, 32'h4332_2110);
            if (i == 0) chk("s2_first_owner", owner, 2'd0);
            if (i == DW) chk("s2_second_owner", owner, 2'd1);
        end

        // Single requester 1 held, byte changes mid-grant.
        pulse_reset("s3_rst");
        for (int i = 0; i < 6; i++) cyc("s3_a", 4'b0010, 32'h0000_0000);
        cyc("s3_b", 4'b0010, 32'h0000_FF00);
        chk("s3_ff", hex_byte, 8'hFF);
        for (int i = 0; i < 9; i++) cyc("s3_c", 4'b0010, 32'h0000_FF00);

        // Reset mid-hold for owner 3, then 0 and 3 together.
        pulse_reset("s4_pre");
        cyc("s4_g3", 4'b1000, 32'hC300_0000);
        cyc("s4_h3", 4'b1000, 32'hC300_0000);
        pulse_reset("s4_rst");
        chk("s4_hex_zero", hex_byte, 8'h00);
        cyc("s4_after", 4'b1001, 32'hC300_0011);
        chk("s4_owner0", owner, 2'd0);
        for (int i = 0; i < 8; i++) cyc("s4_run", 4'b1001, 32'hC300_0011);

        // Requester 0 rises while 2 holds at count 1.
        pulse_reset("s5_rst");
        cyc("s5_g2", 4'b0100, 32'h0022_0000);
        cyc("s5_c1", 4'b0100, 32'h0022_0000);
        for (int i = 0; i < 8; i++) cyc("s5_r0", 4'b0101, 32'h0022_0001);

        // Random traffic with occasional held request vectors and one reset.
        begin
            logic [3:0] r;
            r = 4'b0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 9) < 6) r = 4'($urandom_range(0, 15));
                cyc("rand", r, $urandom);
                if (i == 200) pulse_reset("rand_rst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
